branch_predictor_gshare: RTL and testbench
==========================================

// Module: branch_predictor_gshare
// PURPOSE
//   Parametrised dual-lane branch direction predictor for the superscalar front end.
//   Table of CTR_W-bit saturating counters, indexed bimodal (PC) or gshare (PC ^ GHR) per MODE.
//   Speculative global history with mispredict recovery; table cleared by a sweep FSM after reset.
//   Lane 1 = older instruction of each fetch/execute bundle.
// PARAMETERS
//   PC_W   8   PC width in bits
//   IDX_W  6   table index width; table has 2**IDX_W entries
//   CTR_W  2   counter width in bits (>=2)
//   GHR_W  4   global history width (1..IDX_W)
//   MODE   1   0 = bimodal index, 1 = gshare index
//   CNT_W  16  mispredict counter width
// PORTS
//   clk            in   1      clock, rising edge
//   reset          in   1      synchronous, active-low
//   fetch_en       in   1      fetch bundle accepted this cycle (0 = stall)
//   fbranch1/2     in   1      fetch lane is a conditional branch (predecode)
//   pc1/pc2        in   PC_W   fetch-lane PCs
//   prediction1/2  out  1      predicted taken, combinational
//   ghr_snap1/2    out  GHR_W  history used to index each lane; travels with the instruction
//   branch1/2      in   1      execute lane holds a resolved branch
//   branch_taken1/2 in  1      resolved direction
//   pcE1/pcE2      in   PC_W   execute-lane PCs
//   ghrE1/ghrE2    in   GHR_W  ghr_snap carried to execute
//   mispredict1/2  in   1      execute lane direction was mispredicted (valid only with branchN)
//   ready          out  1      table initialised; predictor live
//   mispred_count  out  CNT_W  saturating count of accepted mispredicts
// BEHAVIOUR
// - Index: bimodal idx = pc[IDX_W-1:0]; gshare idx = pc[IDX_W-1:0] ^ zero-extended history.
// - Fetch histories: lane1 uses ghr.
// - Lane2 uses {ghr[GHR_W-2:0],prediction1} if fbranch1, else ghr.
// - Execute updates index with ghrE1/ghrE2.
// - predictionN = MSB of indexed counter; forced 0 while ready=0.
// - ghr_snapN = history used by lane N; valid in every cycle.
// - Counter update: taken -> +1 saturating at all-ones; not taken -> -1 saturating at 0.
// - Counter init value = 2**(CTR_W-1)-1 (weakly not taken).
// - Reset (reset=0 at edge): ghr<=0, mispred_count<=0, ready<=0, FSM->INIT, sweep ptr<=0.
// - Table not written during reset.
// - FSM INIT: write init value to entry ptr, ptr++, one entry per cycle.
//   * After entry 2**IDX_W-1, go to RUN; ready=1 from the next cycle.
//   * Takes exactly 2**IDX_W cycles.
// - FSM RUN: ready=1; stays until reset.
// - Reset asserted mid-sweep restarts the sweep from entry 0.
// - In INIT: execute updates, ghr shifts, mispredict counting all ignored.
// - GHR, RUN, priority order:
//   1) mispredict1: ghr <= {ghrE1[GHR_W-2:0], branch_taken1}.
//   2) else mispredict2: ghr <= {ghrE2[GHR_W-2:0], branch_taken2}.
//   3) else fetch_en: shift in prediction1 if fbranch1, then prediction2 if fbranch2
//      (0, 1 or 2 bits; lane1 bit older).
//   4) else hold.
// - Recovery overrides a same-cycle fetch shift.
// - Table update, RUN: lane1 updates if branch1.
// - Lane2 updates if branch2 && !(branch1 && mispredict1); a lane1 mispredict squashes lane2.
// - Both lanes hit the same index: apply lane1 step then lane2 step, each saturating,
//   as one write (01 + T,T -> 11; 11 + T,N -> 10).
// - Updates take effect next cycle; same-cycle fetch sees the old value (no bypass).
// - mispred_count += 1 per accepted mispredict (lane2 only if not squashed); saturates at all-ones.
// - Two accepted mispredicts add 2, saturating.
// - MODE=0: ghr and snapshots still maintained; index ignores history.
// TESTING
//   T1 reset 3 cycles then release (IDX_W=6) -> ready=0 for 64 cycles then 1; all predictions 0.
//   T2 MODE=0: branch1,pcE1=0x05,taken x2 -> pc1=0x05 prediction 0->1->1; then not-taken x1 -> still 1.
//   T3 ctr[idx]=01; both lanes same pcE, taken,taken -> ctr 11.
//   T4 ctr[idx]=01; mispredict1 with lane2 same idx taken -> only lane1 applied (10); count +1.
//   T5 MODE=1, ghr=0000, fetch_en, fbranch1=fbranch2=1, preds 1,0 -> ghr=0010; lane2 snap=0001.
//   T6 mispredict1, ghrE1=1010, taken=1, with fetch_en -> ghr=0101 (recovery wins); count +1.
//   T7 CNT_W=2: 5 mispredicts -> mispred_count=3.

Source files
------------

// File: rtl/branch_predictor_gshare.sv
// Dual-lane branch direction predictor.
// The table holds CTR_W-bit saturating counters. Each entry is indexed either by
// the PC alone (bimodal) or by the PC XOR global history (gshare), chosen by MODE.
// Global history is updated speculatively from fetch predictions and is restored
// from the execute-stage snapshot when a mispredict resolves.
// After reset, a sweep FSM writes the init value into every entry, one entry per
// cycle. The predictor is live only once that sweep is done.
// Lane 1 is always the older instruction of a bundle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | sweeping the table to the init value; predictions forced 0
// ST_RUN  | table live; fetch predicts, execute trains, history tracks
module branch_predictor_gshare #(
  parameter int PC_W  = 8,
  parameter int IDX_W = 6,
  parameter int CTR_W = 2,
  parameter int GHR_W = 4,
  parameter int MODE  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_en,
  input  logic             fbranch1,
  input  logic             fbranch2,
  input  logic [PC_W-1:0]  pc1,
  input  logic [PC_W-1:0]  pc2,
  output logic             prediction1,
  output logic             prediction2,
  output logic [GHR_W-1:0] ghr_snap1,
  output logic [GHR_W-1:0] ghr_snap2,
  input  logic             branch1,
  input  logic             branch2,
  input  logic             branch_taken1,
  input  logic             branch_taken2,
  input  logic [PC_W-1:0]  pcE1,
  input  logic [PC_W-1:0]  pcE2,
  input  logic [GHR_W-1:0] ghrE1,
  input  logic [GHR_W-1:0] ghrE2,
  input  logic             mispredict1,
  input  logic             mispredict2,
  output logic             ready,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((2 ** (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CTR_W-1:0] table_q [ENTRIES];

  // In bimodal mode the history argument is deliberately ignored.
  function automatic logic [IDX_W-1:0] calc_idx(input logic [PC_W-1:0]  pc,
                                                 input logic [GHR_W-1:0] hist);
    logic [IDX_W-1:0] hist_ext;
    hist_ext = IDX_W'(hist);
    if (MODE == 0) return pc[IDX_W-1:0];
    else           return pc[IDX_W-1:0] ^ hist_ext;
  endfunction

  // Shift one bit into the youngest position. The wide temporary keeps this
  // legal when GHR_W is 1.
  function automatic logic [GHR_W-1:0] shift_in(input logic [GHR_W-1:0] hist,
                                                 input logic             b);
    logic [GHR_W:0] tmp;
    tmp = {hist, b};
    return tmp[GHR_W-1:0];
  endfunction

  function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c,
                                                 input logic             taken);
    if (taken) return (c == CTR_MAX) ? c : c + 1'b1;
    else       return (c == '0)      ? c : c - 1'b1;
  endfunction

  logic             run;
  logic [GHR_W-1:0] hist1, hist2;
  logic [IDX_W-1:0] fidx1, fidx2;
  logic             pred1, pred2;

  assign run = (state_q == ST_RUN);

  // Fetch side: lane 2 sees lane 1's fresh prediction when lane 1 is a branch.
  always_comb begin
    hist1 = ghr_q;
    fidx1 = calc_idx(pc1, hist1);
    pred1 = run & table_q[fidx1][CTR_W-1];
    hist2 = fbranch1 ? shift_in(ghr_q, pred1) : ghr_q;
    fidx2 = calc_idx(pc2, hist2);
    pred2 = run & table_q[fidx2][CTR_W-1];
  end

  assign prediction1   = pred1;
  assign prediction2   = pred2;
  assign ghr_snap1     = hist1;
  assign ghr_snap2     = hist2;
  assign ready         = run;
  assign mispred_count = cnt_q;

  logic             acc1, acc2;
  logic             mp1, mp2;
  logic [IDX_W-1:0] eidx1, eidx2;
  logic [CTR_W-1:0] new1, base2, new2;

  // Execute side: lane 1 mispredict squashes the younger lane. When both lanes
  // hit the same entry, lane 2 steps from lane 1's result so that a single
  // write carries both updates.
  always_comb begin
    acc1  = run & branch1;
    mp1   = acc1 & mispredict1;
    acc2  = run & branch2 & ~mp1;
    mp2   = acc2 & mispredict2;
    eidx1 = calc_idx(pcE1, ghrE1);
    eidx2 = calc_idx(pcE2, ghrE2);
    new1  = ctr_step(table_q[eidx1], branch_taken1);
    base2 = (acc1 && (eidx1 == eidx2)) ? new1 : table_q[eidx2];
    new2  = ctr_step(base2, branch_taken2);
  end

  // Sweep FSM: walk the pointer across the table once, then stay live.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  logic [GHR_W-1:0] fetch_hist;

  // History next-state: recovery beats any same-cycle fetch shift.
  always_comb begin
    fetch_hist = fbranch2 ? shift_in(hist2, pred2) : hist2;
    ghr_d      = ghr_q;
    if (run) begin
      if (mp1)           ghr_d = shift_in(ghrE1, branch_taken1);
      else if (mp2)      ghr_d = shift_in(ghrE2, branch_taken2);
      else if (fetch_en) ghr_d = fetch_hist;
    end
  end

  logic [1:0]     inc;
  logic [CNT_W:0] cnt_sum;

  // Saturating mispredict counter; the carry bit flags overflow.
  always_comb begin
    inc     = {1'b0, mp1} + {1'b0, mp2};
    cnt_sum = {1'b0, cnt_q} + (CNT_W + 1)'(inc);
    cnt_d   = cnt_sum[CNT_W] ? CNT_MAX : cnt_sum[CNT_W-1:0];
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      ghr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ghr_q   <= ghr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter table: sweep writes during init; training writes once live.
  // When both lanes hit one entry, the lane 2 write lands last and already
  // holds the combined result.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (!run) begin
        table_q[ptr_q] <= CTR_INIT;
      end else begin
        if (acc1) table_q[eidx1] <= new1;
        if (acc2) table_q[eidx2] <= new2;
      end
    end
  end

  generate
    if (PC_W > IDX_W) begin : g_unused_pc
      logic unused_pc_bits;
      assign unused_pc_bits = ^{pc1[PC_W-1:IDX_W], pc2[PC_W-1:IDX_W],
                                pcE1[PC_W-1:IDX_W], pcE2[PC_W-1:IDX_W]};
    end
  endgenerate

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for branch_predictor_gshare: a gshare/16-bit-count instance
// and a bimodal/2-bit-count instance share one stimulus stream.
module tb_branch_predictor_gshare;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch_en, fbranch1, fbranch2;
  logic [7:0] pc1, pc2, pcE1, pcE2;
  logic       branch1, branch2, branch_taken1, branch_taken2;
  logic [3:0] ghrE1, ghrE2;
  logic       mispredict1, mispredict2;

  logic        p1_g, p2_g, ready_g;
  logic [3:0]  s1_g, s2_g;
  logic [15:0] cnt_g;
  logic        p1_b, p2_b, ready_b;
  logic [3:0]  s1_b, s2_b;
  logic [1:0]  cnt_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  branch_predictor_gshare dut_g (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .fbranch1(fbranch1), .fbranch2(fbranch2), .pc1(pc1), .pc2(pc2),
    .prediction1(p1_g), .prediction2(p2_g), .ghr_snap1(s1_g), .ghr_snap2(s2_g),
    .branch1(branch1), .branch2(branch2),
    .branch_taken1(branch_taken1), .branch_taken2(branch_taken2),
    .pcE1(pcE1), .pcE2(pcE2), .ghrE1(ghrE1), .ghrE2(ghrE2),
    .mispredict1(mispredict1), .mispredict2(mispredict2),
    .ready(ready_g), .mispred_count(cnt_g)
  );

  branch_predictor_gshare #(.MODE(0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .fbranch1(fbranch1), .fbranch2(fbranch2), .pc1(pc1), .pc2(pc2),
    .prediction1(p1_b), .prediction2(p2_b), .ghr_snap1(s1_b), .ghr_snap2(s2_b),
    .branch1(branch1), .branch2(branch2),
    .branch_taken1(branch_taken1), .branch_taken2(branch_taken2),
    .pcE1(pcE1), .pcE2(pcE2), .ghrE1(ghrE1), .ghrE2(ghrE2),
    .mispredict1(mispredict1), .mispredict2(mispredict2),
    .ready(ready_b), .mispred_count(cnt_b)
  );

  typedef struct {
    logic       fe, fb1, fb2;
    logic [7:0] pc1, pc2;
    logic       br1, bt1, mp1;
    logic [7:0] pce1;
    logic [3:0] ghre1;
    logic       br2, bt2, mp2;
    logic [7:0] pce2;
    logic [3:0] ghre2;
    int         e_p1g, e_p2g, e_s1g, e_s2g, e_cg, e_p1b, e_cb;  // -1 = not checked
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    if (exp >= 0) begin
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t nv();
    vec_t v;
    v = '{default: 0};
    v.e_p1g = -1; v.e_p2g = -1; v.e_s1g = -1; v.e_s2g = -1;
    v.e_cg  = -1; v.e_p1b = -1; v.e_cb  = -1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    fetch_en = v.fe; fbranch1 = v.fb1; fbranch2 = v.fb2;
    pc1 = v.pc1; pc2 = v.pc2;
    branch1 = v.br1; branch_taken1 = v.bt1; mispredict1 = v.mp1;
    pcE1 = v.pce1; ghrE1 = v.ghre1;
    branch2 = v.br2; branch_taken2 = v.bt2; mispredict2 = v.mp2;
    pcE2 = v.pce2; ghrE2 = v.ghre2;
  endtask

  task automatic build_vectors();
    vec_t v;
    // T2: bimodal/gshare train entry 0x05 (ghr = 0, so both index 0x05)
    v = nv(); v.pc1 = 8'h05; v.br1 = 1; v.bt1 = 1; v.pce1 = 8'h05;
    v.e_p1g = 0; v.e_p1b = 0; v.e_p2g = 0; v.e_s1g = 0; v.e_s2g = 0; v.e_cg = 0; v.e_cb = 0;
    vecs.push_back(v);
    v = nv(); v.pc1 = 8'h05; v.br1 = 1; v.bt1 = 1; v.pce1 = 8'h05; v.e_p1g = 1; v.e_p1b = 1;
    vecs.push_back(v);
    v = nv(); v.pc1 = 8'h05; v.br1 = 1; v.bt1 = 0; v.pce1 = 8'h05; v.e_p1g = 1; v.e_p1b = 1;
    vecs.push_back(v);
    v = nv(); v.pc1 = 8'h05; v.e_p1g = 1; v.e_p1b = 1;
    vecs.push_back(v);
    // T3: both lanes taken on 0x10 (01 -> 11), then one not-taken keeps it at 10
    v = nv(); v.pc1 = 8'h10; v.br1 = 1; v.bt1 = 1; v.pce1 = 8'h10;
    v.br2 = 1; v.bt2 = 1; v.pce2 = 8'h10; v.e_p1g = 0; v.e_p1b = 0;
    vecs.push_back(v);
    v = nv(); v.pc1 = 8'h10; v.e_p1g = 1; v.e_p1b = 1;
    vecs.push_back(v);
    v = nv(); v.pc1 = 8'h10; v.br1 = 1; v.bt1 = 0; v.pce1 = 8'h10; v.e_p1g = 1; v.e_p1b = 1;
    vecs.push_back(v);
    v = nv(); v.pc1 = 8'h10; v.e_p1g = 1; v.e_p1b = 1;
    vecs.push_back(v);
    // 0x20: 01 +T,T -> 11; 11 +T,N -> 10; -1 -> 01
    v = nv(); v.pc1 = 8'h20; v.br1 = 1; v.bt1 = 1; v.pce1 = 8'h20;
    v.br2 = 1; v.bt2 = 1; v.pce2 = 8'h20; v.e_p1g = 0; v.e_p1b = 0;
    vecs.push_back(v);
    v = nv(); v.pc1 = 8'h20; v.br1 = 1; v.bt1 = 1; v.pce1 = 8'h20;
    v.br2 = 1; v.bt2 = 0; v.pce2 = 8'h20; v.e_p1g = 1; v.e_p1b = 1;
    vecs.push_back(v);
    v = nv(); v.pc1 = 8'h20; v.br1 = 1; v.bt1 = 0; v.pce1 = 8'h20; v.e_p1g = 1; v.e_p1b = 1;
    vecs.push_back(v);
    v = nv(); v.pc1 = 8'h20; v.e_p1g = 0; v.e_p1b = 0;
    vecs.push_back(v);
    // T4: lane1 mispredict on 0x30 squashes lane2 on the same entry
    v = nv(); v.pc1 = 8'h30; v.br1 = 1; v.bt1 = 1; v.mp1 = 1; v.pce1 = 8'h30;
    v.br2 = 1; v.bt2 = 1; v.pce2 = 8'h30;
    v.e_p1g = 0; v.e_p1b = 0; v.e_s1g = 0; v.e_cg = 0; v.e_cb = 0;
    vecs.push_back(v);
    v = nv(); v.pc1 = 8'h30; v.br1 = 1; v.bt1 = 0; v.pce1 = 8'h30;
    v.e_p1g = 0; v.e_p1b = 1; v.e_s1g = 1; v.e_s2g = 1; v.e_cg = 1; v.e_cb = 1;
    vecs.push_back(v);
    v = nv(); v.pc1 = 8'h30; v.pc2 = 8'h31;
    v.e_p1g = 0; v.e_p1b = 0; v.e_p2g = 0; v.e_s1g = 1;
    vecs.push_back(v);
    // restore ghr to 0000 via recovery
    v = nv(); v.pc1 = 8'h05; v.br1 = 1; v.bt1 = 0; v.mp1 = 1; v.pce1 = 8'h3F;
    v.e_p1g = 0; v.e_p1b = 1; v.e_s1g = 1; v.e_cg = 1; v.e_cb = 1;
    vecs.push_back(v);
    // T5: two fetched branches, predictions 1 then 0
    v = nv(); v.fe = 1; v.fb1 = 1; v.fb2 = 1; v.pc1 = 8'h05; v.pc2 = 8'h08;
    v.e_p1g = 1; v.e_p1b = 1; v.e_p2g = 0; v.e_s1g = 0; v.e_s2g = 1; v.e_cg = 2; v.e_cb = 2;
    vecs.push_back(v);
    // T6: recovery overrides fetch shift
    v = nv(); v.fe = 1; v.fb1 = 1; v.fb2 = 1; v.pc1 = 8'h05; v.pc2 = 8'h08;
    v.br1 = 1; v.bt1 = 1; v.mp1 = 1; v.pce1 = 8'h3A; v.ghre1 = 4'hA;
    v.e_p1g = 0; v.e_p1b = 1; v.e_p2g = 0; v.e_s1g = 2; v.e_s2g = 4; v.e_cg = 2; v.e_cb = 2;
    vecs.push_back(v);
    v = nv(); v.pc1 = 8'h05; v.e_s1g = 5; v.e_p1g = 0; v.e_p1b = 1; v.e_cg = 3; v.e_cb = 3;
    vecs.push_back(v);
    // both lanes mispredict: lane2 squashed, lane1 history wins
    v = nv(); v.br1 = 1; v.bt1 = 0; v.mp1 = 1; v.pce1 = 8'h3F;
    v.br2 = 1; v.bt2 = 1; v.mp2 = 1; v.pce2 = 8'h3E;
    v.e_s1g = 5; v.e_cg = 3; v.e_cb = 3;
    vecs.push_back(v);
    // lane2-only mispredict recovers from ghrE2
    v = nv(); v.br1 = 1; v.bt1 = 1; v.pce1 = 8'h3D;
    v.br2 = 1; v.bt2 = 1; v.mp2 = 1; v.pce2 = 8'h3C; v.ghre2 = 4'h3;
    v.e_s1g = 0; v.e_cg = 4; v.e_cb = 3;
    vecs.push_back(v);
    v = nv(); v.e_s1g = 7; v.e_cg = 5; v.e_cb = 3;
    vecs.push_back(v);
    // only lane2 is a branch
    v = nv(); v.fe = 1; v.fb2 = 1; v.pc2 = 8'h06; v.e_s1g = 7; v.e_s2g = 7; v.e_p2g = 0;
    vecs.push_back(v);
    // stall holds history
    v = nv(); v.fb1 = 1; v.fb2 = 1; v.e_s1g = 14;
    vecs.push_back(v);
    v = nv(); v.e_s1g = 14;
    vecs.push_back(v);
  endtask

  initial begin
    int n;
    vec_t v;
    reset = 1'b0;
    v = nv();
    drive(v);
    build_vectors();

    // T1: reset held 3 cycles; predictions forced low
    fetch_en = 1; fbranch1 = 1; pc1 = 8'h05;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready_g", int'(ready_g), 0);
    chk("reset_pred1_g", int'(p1_g), 0);
    chk("reset_cnt_g", int'(cnt_g), 0);

    // INIT must ignore execute mispredicts and history updates
    branch1 = 1; branch_taken1 = 1; mispredict1 = 1; pcE1 = 8'h05; ghrE1 = 4'hF;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("init_ready_g", int'(ready_g), 0);
    chk("init_pred1_b", int'(p1_b), 0);

    // Reset mid-sweep restarts from entry 0
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    n = 0;
    while (!ready_g && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("init_cycles", n, 64);
    chk("init_ready_b", int'(ready_b), 1);
    chk("init_ghr_g", int'(s1_g), 0);
    chk("init_cnt_g", int'(cnt_g), 0);
    chk("init_cnt_b", int'(cnt_b), 0);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_pred1_g", i), int'(p1_g), vecs[i].e_p1g);
      chk($sformatf("v%0d_pred2_g", i), int'(p2_g), vecs[i].e_p2g);
      chk($sformatf("v%0d_snap1_g", i), int'(s1_g), vecs[i].e_s1g);
      chk($sformatf("v%0d_snap2_g", i), int'(s2_g), vecs[i].e_s2g);
      chk($sformatf("v%0d_cnt_g", i), int'(cnt_g), vecs[i].e_cg);
      chk($sformatf("v%0d_pred1_b", i), int'(p1_b), vecs[i].e_p1b);
      chk($sformatf("v%0d_cnt_b", i), int'(cnt_b), vecs[i].e_cb);
      @(posedge clk);
      #1;
    end

    // Reset while live: entry 0x05 of the bimodal table is 10, yet output stays 0
    v = nv();
    v.pc1 = 8'h05;
    drive(v);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rerun_ready_g", int'(ready_g), 0);
    chk("rerun_pred1_b", int'(p1_b), 0);
    chk("rerun_cnt_g", int'(cnt_g), 0);
    chk("rerun_cnt_b", int'(cnt_b), 0);
    chk("rerun_ghr_g", int'(s1_g), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
